seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_pkg.sv | 18 +
 rtl/ripple_carry_adder.sv | 24 ++
 rtl/seq_multiplier.sv | 103 ++++++++++
 tb/tb_seq_multiplier.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: operand and
// product widths, iteration count and the controller state encoding.
package seq_multiplier_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int ITER   = 8;
  // Wide enough to hold ITER itself so the increment on the last RUN
  // cycle does not wrap.
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// 8-bit ripple-carry adder used as the accumulate path of seq_multiplier.
module ripple_carry_adder
  import seq_multiplier_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cy_in,
  output logic [OP_W-1:0] sum,
  output logic            cy_out
);

  // Bit-serial carry chain, LSB to MSB.
  always_comb begin
    logic cy;
    sum = '0;
    cy  = cy_in;
    for (int i = 0; i < OP_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cy_out = cy;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned 8x8 sequential shift-add multiplier. One partial product per
// cycle over eight RUN cycles; the result is presented for one DONE cycle
// and then held until the next start is accepted.
module seq_multiplier
  import seq_multiplier_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_t              state;
  logic [OP_W-1:0]     m_reg;
  logic [OP_W-1:0]     q_reg;
  logic [OP_W-1:0]     acc;
  logic                c_reg;
  logic [CNT_W-1:0]    count;

  logic [OP_W-1:0]     add_sum;
  logic                add_cy;
  logic [OP_W-1:0]     acc_add;
  logic                c_add;
  logic [OP_W-1:0]     acc_shift;
  logic [OP_W-1:0]     q_shift;
  logic                c_shift;

  // Carry-in is tied low; the carry-out becomes C so the partial sum keeps
  // its ninth bit until the shift moves it into A.
  ripple_carry_adder u_adder (
    .a      (acc),
    .b      (m_reg),
    .cy_in  (1'b0),
    .sum    (add_sum),
    .cy_out (add_cy)
  );

  // One iteration: conditional add of M into {C,A}, then shift {C,A,Q} right.
  always_comb begin
    if (q_reg[0]) begin
      c_add   = add_cy;
      acc_add = add_sum;
    end else begin
      c_add   = c_reg;
      acc_add = acc;
    end
    c_shift   = 1'b0;
    acc_shift = {c_add, acc_add[OP_W-1:1]};
    q_shift   = {acc_add[0], q_reg[OP_W-1:1]};
  end

  // Controller and datapath registers; reset wins over start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      m_reg   <= '0;
      q_reg   <= '0;
      acc     <= '0;
      c_reg   <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg   <= a;
            q_reg   <= b;
            acc     <= '0;
            c_reg   <= 1'b0;
            count   <= '0;
            product <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_shift;
          q_reg <= q_shift;
          c_reg <= c_shift;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(ITER - 1)) begin
            product <= {acc_shift, q_shift};
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status flags come straight from the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier: directed vector table, hand-written
// multi-cycle sequences, and random operands against a plain a*b model.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int passed = 0;

  seq_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_in),
    .b       (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    else
      passed++;
  endtask

  // Runs one multiply from an idle DUT and observes a fixed 12-cycle window
  // after the accept edge. Cycle index 1 is the cycle right after acceptance.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output logic [15:0] prod, output int lat,
                        output int busy_cnt, output int done_cnt,
                        output logic [15:0] clr_val, output logic [15:0] hold_val);
    @(posedge clk); #1;
    start = 1'b1; a_in = av; b_in = bv;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = 8'($urandom);
    b_in = 8'($urandom);
    prod = '0; lat = 0; busy_cnt = 0; done_cnt = 0;
    clr_val = product;
    for (int idx = 1; idx <= 12; idx++) begin
      if (idx > 1) begin
        @(posedge clk); #1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) begin
          lat  = idx;
          prod = product;
        end
      end
    end
    hold_val = product;
  endtask

  logic [15:0] prod, clr_val, hold_val;
  int lat, busy_cnt, done_cnt;

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] model;
    int          done_idx[$];
    int          last_done;

    vecs[0] = '{8'd13,  8'd11,  16'd143};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'd0};
    vecs[3] = '{8'd1,   8'd200, 16'd200};
    vecs[4] = '{8'd200, 8'd0,   16'd0};
    vecs[5] = '{8'd128, 8'd2,   16'd256};
    vecs[6] = '{8'd255, 8'd1,   16'd255};
    vecs[7] = '{8'd15,  8'd17,  16'd255};

    // Reset held with start high: reset must win.
    rst_n = 1'b0; start = 1'b1; a_in = 8'd5; b_in = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    // Directed vector table.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, prod, lat, busy_cnt, done_cnt, clr_val, hold_val);
      check($sformatf("vec%0d_product", i), 32'(prod), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt), 32'd8);
      check($sformatf("vec%0d_done_pulses", i), 32'(done_cnt), 32'd1);
      check($sformatf("vec%0d_clear_on_start", i), 32'(clr_val), 32'd0);
      check($sformatf("vec%0d_hold", i), 32'(hold_val), 32'(vecs[i].exp));
    end

    // Second start during RUN cycle 3 is ignored.
    @(posedge clk); #1;
    start = 1'b1; a_in = 8'd6; b_in = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; done_cnt = 0; prod = '0;
    for (int idx = 1; idx <= 14; idx++) begin
      if (idx > 1) begin
        @(posedge clk); #1;
      end
      if (idx == 3) begin
        start = 1'b1; a_in = 8'd9; b_in = 8'd9;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (lat == 0) begin
          lat = idx;
          prod = product;
        end
      end
    end
    check("ignore_product", 32'(prod), 32'd42);
    check("ignore_latency", 32'(lat), 32'd9);
    check("ignore_done_pulses", 32'(done_cnt), 32'd1);

    // Reset during RUN cycle 4 aborts with no done pulse.
    @(posedge clk); #1;
    start = 1'b1; a_in = 8'd100; b_in = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    for (int idx = 1; idx <= 14; idx++) begin
      if (idx > 1) begin
        @(posedge clk); #1;
      end
      if (done) done_cnt++;
      if (idx == 4) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_product", 32'(product), 32'd0);
      end
    end
    check("abort_done_pulses", 32'(done_cnt), 32'd0);
    check("abort_product_after", 32'(product), 32'd0);
    run_op(8'd6, 8'd7, prod, lat, busy_cnt, done_cnt, clr_val, hold_val);
    check("post_abort_product", 32'(prod), 32'd42);
    check("post_abort_latency", 32'(lat), 32'd9);

    // Start held high: back-to-back multiplies every 10 cycles.
    @(posedge clk); #1;
    start = 1'b1; a_in = 8'd2; b_in = 8'd3;
    @(posedge clk); #1;
    last_done = -10;
    for (int idx = 1; idx <= 32; idx++) begin
      if (idx > 1) begin
        @(posedge clk); #1;
      end
      if (done) begin
        done_idx.push_back(idx);
        last_done = idx;
        check("b2b_product", 32'(product), 32'd6);
      end else if (idx == last_done + 1) begin
        check("b2b_hold", 32'(product), 32'd6);
      end
    end
    start = 1'b0;
    check("b2b_pulse_count", 32'(done_idx.size()), 32'd3);
    if (done_idx.size() == 3) begin
      check("b2b_first", 32'(done_idx[0]), 32'd9);
      check("b2b_gap1", 32'(done_idx[1] - done_idx[0]), 32'd10);
      check("b2b_gap2", 32'(done_idx[2] - done_idx[1]), 32'd10);
    end
    repeat (12) @(posedge clk);
    #1;

    // Random operands against the arithmetic model.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      model = 16'(ra) * 16'(rb);
      run_op(ra, rb, prod, lat, busy_cnt, done_cnt, clr_val, hold_val);
      check($sformatf("rand%0d_product_%0dx%0d", n, ra, rb), 32'(prod), 32'(model));
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'd9);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
